sram_port_ctrl: RTL and testbench
=================================

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 Parameter: WR_CYCLES, default 2, number of cycles the write strobe is held low (legal 1..15).
REQ-002 Parameter: RD_CYCLES, default 2, number of cycles the output enable is held low before the read sample (legal 1..15).
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 en  in  1  controller enable; 0 deselects both SRAMs and aborts any access.
REQ-006 re  in  1  read request, sampled in IDLE.
REQ-007 we  in  1  write request, sampled in IDLE; takes priority over re.
REQ-008 addr  in  17  bit16 selects the chip (0=ram1, 1=ram2); bits 15:0 are the word address.
REQ-009 data_in  in  16  write data.
REQ-010 data_out  out  16  registered read data.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 busy  out  1  high while the FSM is outside IDLE.
REQ-013 err  out  1  write-verify mismatch flag.
REQ-014 ram1EN/ram1OE/ram1WE and ram2EN/ram2OE/ram2WE  out  1 each  SRAM controls, active-low.
REQ-015 ram_addr1, ram_addr2  out  18  SRAM address; value is {2'b00, latched addr[15:0]}.
REQ-016 ram_data1, ram_data2  inout  16  SRAM data; driven only during a write to that chip, otherwise Z.

Function
REQ-017 States: IDLE, SETUP, WR_PULSE, WR_HOLD, RD_OE, DONE, plus VFY_TURN and VFY_OE when the verify feature is compiled in.
REQ-018 IDLE, with en=1 and we=1: latch addr and data_in, go to SETUP, write access.
REQ-019 IDLE, with en=1, re=1 and we=0: latch addr, go to SETUP, read access.
REQ-020 Requests arriving while busy=1 are ignored, with no queuing.
REQ-021 SETUP lasts 1 cycle: selected EN=0, OE=1, WE=1; on a write, data is driven onto the selected bus.
REQ-022 WR_PULSE lasts WR_CYCLES cycles: WE=0, data driven.
REQ-023 WR_HOLD lasts 1 cycle: WE=1, data still driven; then go to DONE (or VFY_TURN).
REQ-024 RD_OE lasts RD_CYCLES cycles: OE=0, bus Z; at the edge leaving the state, the bus is captured into data_out and the FSM goes to DONE.
REQ-025 DONE lasts 1 cycle: done=1, selected EN=0, OE/WE=1, bus Z; then go to IDLE.
REQ-026 Write latency: done is high in the cycle after edge WR_CYCLES+2, counted from the accepting edge E0.
REQ-027 Read latency: done is high in the cycle after edge RD_CYCLES+1 from E0.
REQ-028 The unselected chip always has EN=OE=WE=1 and bus Z.
REQ-029 In IDLE, both chips have EN=OE=WE=1 and buses are Z.
REQ-030 A chip's bus is never driven while its OE=0.
REQ-031 Both re and we asserted together are treated as a write only.
REQ-032 en=0 in any non-IDLE state: next edge goes to IDLE, all controls are deasserted, buses are Z, there is no done pulse, and data_out is unchanged.
REQ-033 The internal cycle counter is 4 bits, reloads on each state entry, and never wraps within a state.
REQ-034 data_out changes only on a read capture or a verify capture.

Reset
REQ-035 rst=0 asynchronously forces: state=IDLE, data_out=0, done=0, busy=0, err=0, all EN/OE/WE=1, ram_addr1/2=0, buses Z.
REQ-036 Reset asserted mid-access releases the pins within the same cycle, with no done pulse.

Configuration
REQ-037 Macro SRAM_WRITE_VERIFY_EN.
REQ-038 Verify defined: WR_HOLD goes to VFY_TURN (1 cycle, bus Z, OE=1), then VFY_OE (RD_CYCLES cycles, OE=0).
REQ-039 Verify defined: VFY_OE captures the bus into data_out, sets err=1 if the captured value differs from the latched data_in, and goes to DONE; write latency becomes WR_CYCLES+RD_CYCLES+3.
REQ-040 Verify defined: err is cleared on the next accepted request.
REQ-041 Verify undefined: err is tied to 0, the VFY states do not exist, and write latency is per REQ-026.

Verification
REQ-042 Defaults: en=1, we pulse, addr=0x00005, data_in=0x1234 -> ram1WE low 2 cycles, ram_addr1=0x00005, ram_data1=0x1234, done in the cycle after edge 4, ram2 idle.
REQ-043 re pulse, addr=0x10005, SRAM model returns 0xBEEF -> ram2OE low 2 cycles, data_out=0xBEEF, done in the cycle after edge 3.
REQ-044 we pulse then re pulse while busy=1 -> second request ignored, exactly one done.
REQ-045 en dropped during WR_PULSE -> all controls high next cycle, no done; rst=0 during RD_OE -> outputs at reset values immediately.
REQ-046 With SRAM_WRITE_VERIFY_EN: write 0x00FF to a model with a stuck bit0 -> data_out=0x00FE, err=1, done in the cycle after edge 7; next clean write -> err=0.
REQ-047 re and we together with data_in=0xA5A5 -> write occurs, no read capture; contention checker confirms the bus is never driven while OE=0.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// Two-chip asynchronous SRAM port controller: one read or write access at a time,
// active-low strobes, optional read-back verify of writes (`SRAM_WRITE_VERIFY_EN).
module sram_port_ctrl #(
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        re,
  input  logic        we,
  input  logic [16:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic        ram1EN,
  output logic        ram1OE,
  output logic        ram1WE,
  output logic        ram2EN,
  output logic        ram2OE,
  output logic        ram2WE,
  output logic [17:0] ram_addr1,
  output logic [17:0] ram_addr2,
  inout  wire  [15:0] ram_data1,
  inout  wire  [15:0] ram_data2
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_OE,
`ifdef SRAM_WRITE_VERIFY_EN
    VFY_TURN,
    VFY_OE,
`endif
    DONE
  } state_t;

  localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        chip_q, chip_nxt;
  logic        wr_q, wr_nxt;
  logic        accept;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        drv1, drv2;
  logic [15:0] rd_bus;
  logic        capture_rd;
  logic        capture_vfy;
  logic        act_nxt, oe_nxt, we_nxt, drv_nxt;

  assign rd_bus    = chip_q ? ram_data2 : ram_data1;
  assign ram_addr1 = {2'b00, addr_q};
  assign ram_addr2 = {2'b00, addr_q};
  assign ram_data1 = drv1 ? wdata_q : 16'bz;
  assign ram_data2 = drv2 ? wdata_q : 16'bz;

  assign capture_rd = en && (state == RD_OE) && (cnt == 4'd0);
`ifdef SRAM_WRITE_VERIFY_EN
  assign capture_vfy = en && (state == VFY_OE) && (cnt == 4'd0);
`else
  assign capture_vfy = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
    chip_nxt  = chip_q;
    wr_nxt    = wr_q;
    accept    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (we || re) begin
            accept    = 1'b1;
            state_nxt = SETUP;
            cnt_nxt   = 4'd0;
            chip_nxt  = addr[16];
            wr_nxt    = we;
          end
        end
        SETUP: begin
          state_nxt = wr_q ? WR_PULSE : RD_OE;
          cnt_nxt   = wr_q ? WR_LOAD : RD_LOAD;
        end
        WR_PULSE: begin
          if (cnt == 4'd0) begin
            state_nxt = WR_HOLD;
            cnt_nxt   = 4'd0;
          end
        end
        WR_HOLD: begin
`ifdef SRAM_WRITE_VERIFY_EN
          state_nxt = VFY_TURN;
`else
          state_nxt = DONE;
`endif
          cnt_nxt   = 4'd0;
        end
`ifdef SRAM_WRITE_VERIFY_EN
        VFY_TURN: begin
          state_nxt = VFY_OE;
          cnt_nxt   = RD_LOAD;
        end
        VFY_OE: begin
          if (cnt == 4'd0) begin
            state_nxt = DONE;
            cnt_nxt   = 4'd0;
          end
        end
`endif
        RD_OE: begin
          if (cnt == 4'd0) begin
            state_nxt = DONE;
            cnt_nxt   = 4'd0;
          end
        end
        DONE: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Pin controls are decoded from the next state so they are registered yet
  // line up with the state they belong to.
  always_comb begin
    act_nxt = (state_nxt != IDLE);
    oe_nxt  = (state_nxt == RD_OE);
`ifdef SRAM_WRITE_VERIFY_EN
    oe_nxt  = oe_nxt || (state_nxt == VFY_OE);
`endif
    we_nxt  = (state_nxt == WR_PULSE);
    drv_nxt = ((state_nxt == SETUP) && wr_nxt) || (state_nxt == WR_PULSE) ||
              (state_nxt == WR_HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // asynchronous reset puts every register (including the pins) in a safe state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      chip_q   <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      data_out <= 16'h0000;
      done     <= 1'b0;
      busy     <= 1'b0;
      ram1EN   <= 1'b1;
      ram1OE   <= 1'b1;
      ram1WE   <= 1'b1;
      ram2EN   <= 1'b1;
      ram2OE   <= 1'b1;
      ram2WE   <= 1'b1;
      drv1     <= 1'b0;
      drv2     <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      chip_q <= chip_nxt;
      wr_q   <= wr_nxt;
      if (accept) begin
        addr_q <= addr[15:0];
        if (we) wdata_q <= data_in;
      end
      if (capture_rd || capture_vfy) data_out <= rd_bus;
      done   <= (state_nxt == DONE);
      busy   <= act_nxt;
      ram1EN <= !(act_nxt && !chip_nxt);
      ram1OE <= !(oe_nxt  && !chip_nxt);
      ram1WE <= !(we_nxt  && !chip_nxt);
      ram2EN <= !(act_nxt &&  chip_nxt);
      ram2OE <= !(oe_nxt  &&  chip_nxt);
      ram2WE <= !(we_nxt  &&  chip_nxt);
      drv1   <= drv_nxt && !chip_nxt;
      drv2   <= drv_nxt &&  chip_nxt;
    end
  end

`ifdef SRAM_WRITE_VERIFY_EN
  logic err_q;

  // A mismatch stays visible until the next request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (capture_vfy) begin
      err_q <= (rd_bus != wdata_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl: vector table of single accesses against two
// small SRAM models, plus hand sequences for busy, abort, reset and verify cases.
module tb_sram_port_ctrl;
  localparam int WRC = 2;
  localparam int RDC = 2;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam int WR_LAT = WRC + RDC + 3;
`else
  localparam int WR_LAT = WRC + 2;
`endif
  localparam int RD_LAT = RDC + 1;

  logic        clk, rst, en, re, we;
  logic [16:0] addr;
  logic [15:0] data_in, data_out;
  logic        done, busy, err;
  logic        ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE;
  logic [17:0] ram_addr1, ram_addr2;
  wire  [15:0] ram_data1, ram_data2;

  sram_port_ctrl #(.WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
    .clk(clk), .rst(rst), .en(en), .re(re), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .done(done), .busy(busy), .err(err),
    .ram1EN(ram1EN), .ram1OE(ram1OE), .ram1WE(ram1WE),
    .ram2EN(ram2EN), .ram2OE(ram2OE), .ram2WE(ram2WE),
    .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_data1(ram_data1), .ram_data2(ram_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: 64 words each, optional stuck-at-0 on bit 0 of written data.
  logic [15:0] mem1 [64];
  logic [15:0] mem2 [64];
  logic        stuck;

  assign ram_data1 = (!ram1EN && !ram1OE) ? mem1[ram_addr1[5:0]] : 16'bz;
  assign ram_data2 = (!ram2EN && !ram2OE) ? mem2[ram_addr2[5:0]] : 16'bz;

  always @(posedge clk) begin
    if (!ram1EN && !ram1WE) mem1[ram_addr1[5:0]] <= stuck ? (ram_data1 & 16'hFFFE) : ram_data1;
    if (!ram2EN && !ram2WE) mem2[ram_addr2[5:0]] <= stuck ? (ram_data2 & 16'hFFFE) : ram_data2;
  end

  // Protocol monitor: while OE is low only the SRAM may drive, WE must be high,
  // and the two chips are never selected together.
  int contention;
  always @(negedge clk) begin
    if (rst) begin
      if (!ram1OE && (!ram1WE || ram_data1 !== mem1[ram_addr1[5:0]])) contention++;
      if (!ram2OE && (!ram2WE || ram_data2 !== mem2[ram_addr2[5:0]])) contention++;
      if (!ram1EN && !ram2EN) contention++;
    end
  end

  int num_vec;
  int num_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_vec++;
    if (act !== exp) begin
      num_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request at the edge E0; index i is "the cycle after edge i".
  task automatic run_txn(input logic w, input logic r, input logic [16:0] a,
                         input logic [15:0] d, output int lat, output int ndone,
                         output int wec, output int oec, output int other,
                         output logic [17:0] seen_addr);
    lat = -1; ndone = 0; wec = 0; oec = 0; other = 0; seen_addr = '0;
    @(negedge clk);
    we = w; re = r; addr = a; data_in = d;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin we = 1'b0; re = 1'b0; end
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (!a[16]) begin
        if (!ram1WE) wec++;
        if (!ram1OE) oec++;
        if (!ram1WE || !ram1OE) seen_addr = ram_addr1;
        if (!ram2EN || !ram2OE || !ram2WE) other++;
      end else begin
        if (!ram2WE) wec++;
        if (!ram2OE) oec++;
        if (!ram2WE || !ram2OE) seen_addr = ram_addr2;
        if (!ram1EN || !ram1OE || !ram1WE) other++;
      end
      if (lat >= 0 && i > lat + 1) break;
    end
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [16:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] exp_dout;
  int          lat, ndone, wec, oec, other, cnt_a, cnt_b;
  logic [17:0] seen;
  logic [15:0] mval;

  initial begin
    for (int i = 0; i < 64; i++) begin mem1[i] = 16'h0000; mem2[i] = 16'h0000; end
    vecs[0] = '{1'b1, 1'b0, 17'h00005, 16'h1234, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 17'h10005, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 17'h10005, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 17'h00005, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 17'h00009, 16'hA5A5, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 17'h1FFFF, 16'hFFFF, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 17'h1FFFF, 16'h0000, 16'hFFFF};
    vecs[7] = '{1'b1, 1'b0, 17'h00000, 16'h0000, 16'h0000};
    vecs[8] = '{1'b0, 1'b1, 17'h00000, 16'h0000, 16'h0000};
    vecs[9] = '{1'b0, 1'b1, 17'h00009, 16'h0000, 16'hA5A5};

    num_vec = 0; num_bad = 0; contention = 0; stuck = 1'b0;
    rst = 1'b0; en = 1'b1; re = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    exp_dout = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_flags", {29'd0, done, busy, err}, 32'h0);
    check("rst_ctrl", {26'd0, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 32'h3F);
    check("rst_addr", {ram_addr1[15:0], ram_addr2[15:0]}, 32'h0);
    rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      run_txn(vecs[v].w, vecs[v].r, vecs[v].a, vecs[v].d, lat, ndone, wec, oec, other, seen);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].w ? WR_LAT : RD_LAT));
      check($sformatf("v%0d_done_count", v), 32'(ndone), 32'd1);
      check($sformatf("v%0d_other_chip", v), 32'(other), 32'd0);
      check($sformatf("v%0d_addr", v), 32'(seen), {14'd0, 2'b00, vecs[v].a[15:0]});
      if (vecs[v].w) begin
        mval = vecs[v].a[16] ? mem2[vecs[v].a[5:0]] : mem1[vecs[v].a[5:0]];
        check($sformatf("v%0d_we_cycles", v), 32'(wec), 32'(WRC));
        check($sformatf("v%0d_mem", v), 32'(mval), 32'(vecs[v].d));
`ifdef SRAM_WRITE_VERIFY_EN
        exp_dout = vecs[v].d;
`endif
      end else begin
        check($sformatf("v%0d_oe_cycles", v), 32'(oec), 32'(RDC));
        check($sformatf("v%0d_we_cycles", v), 32'(wec), 32'd0);
        exp_dout = vecs[v].exp_rd;
      end
      check($sformatf("v%0d_data_out", v), 32'(data_out), 32'(exp_dout));
      check($sformatf("v%0d_err", v), 32'(err), 32'd0);
    end

    // Read request while busy with a write is dropped.
    cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    we = 1'b1; addr = 17'h00011; data_in = 16'h1111;
    @(posedge clk);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) we = 1'b0;
      if (i == 1) begin re = 1'b1; addr = 17'h10005; end
      if (i == 2) re = 1'b0;
      if (done) cnt_a++;
      if (!ram2OE || !ram2EN) cnt_b++;
    end
`ifdef SRAM_WRITE_VERIFY_EN
    exp_dout = 16'h1111;
`endif
    check("busy_done_count", 32'(cnt_a), 32'd1);
    check("busy_ram2_touched", 32'(cnt_b), 32'd0);
    check("busy_mem", 32'(mem1[6'h11]), 32'h1111);
    check("busy_data_out", 32'(data_out), 32'(exp_dout));

    // en dropped during WR_PULSE aborts without done.
    cnt_a = 0;
    @(negedge clk);
    we = 1'b1; addr = 17'h00012; data_in = 16'h2222;
    @(posedge clk);
    @(negedge clk); we = 1'b0;
    @(negedge clk);
    check("abort_in_pulse", 32'(ram1WE), 32'd0);
    en = 1'b0;
    @(negedge clk);
    check("abort_ctrl", {26'd0, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 32'h3F);
    check("abort_busy", 32'(busy), 32'd0);
    we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) cnt_a++;
    end
    we = 1'b0;
    check("abort_no_done", 32'(cnt_a), 32'd0);
    check("abort_data_out", 32'(data_out), 32'(exp_dout));
    en = 1'b1;

    // Reset during RD_OE releases the pins immediately.
    cnt_a = 0;
    @(negedge clk);
    re = 1'b1; addr = 17'h10005;
    @(posedge clk);
    @(negedge clk); re = 1'b0;
    @(negedge clk);
    check("rst_mid_oe_before", 32'(ram2OE), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_ctrl", {26'd0, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 32'h3F);
    check("rst_mid_flags", {29'd0, done, busy, err}, 32'h0);
    check("rst_mid_data_out", 32'(data_out), 32'h0);
    check("rst_mid_addr", 32'(ram_addr2), 32'h0);
    exp_dout = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) cnt_a++;
    end
    check("rst_mid_no_done", 32'(cnt_a), 32'd0);

`ifdef SRAM_WRITE_VERIFY_EN
    stuck = 1'b1;
    run_txn(1'b1, 1'b0, 17'h00020, 16'h00FF, lat, ndone, wec, oec, other, seen);
    stuck = 1'b0;
    check("vfy_latency", 32'(lat), 32'd7);
    check("vfy_data_out", 32'(data_out), 32'h00FE);
    check("vfy_err_set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("vfy_err_held", 32'(err), 32'd1);
    run_txn(1'b1, 1'b0, 17'h00021, 16'h0F0F, lat, ndone, wec, oec, other, seen);
    check("vfy_err_clear", 32'(err), 32'd0);
    check("vfy_clean_data_out", 32'(data_out), 32'h0F0F);
`endif

    check("bus_contention", 32'(contention), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_bad);
    $finish;
  end

endmodule
